seq_div_16by8: RTL

//   Iterative restoring divider: unsigned 16-bit dividend by unsigned 8-bit divisor.
//   It is the inverse-direction companion of the 8x8 approximate multipliers and

---
 rtl/seq_div_16by8.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seq_div_16by8.sv
// Iterative restoring divider: unsigned WIDTH_N-bit dividend by WIDTH_D-bit divisor,
// one quotient bit per clock, with optional skipping of the low APPROX_LSB quotient bits.
module seq_div_16by8 #(
    parameter int WIDTH_N    = 16,
    parameter int WIDTH_D    = 8,
    parameter int APPROX_LSB = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               div_zero
);

    localparam int CNT_W = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;
    localparam int ITERS = WIDTH_N - APPROX_LSB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH_N-1:0] r_dvd;
    logic [WIDTH_D-1:0] r_dvs;
    logic [WIDTH_D-1:0] r_rem;
    logic [WIDTH_N-1:0] r_quo;
    logic [WIDTH_N-1:0] r_q_out;
    logic [WIDTH_D-1:0] r_r_out;
    logic               r_dz_out;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH_D:0]   w_shift;
    logic [WIDTH_D:0]   w_sub;
    logic               w_ge;
    logic [WIDTH_D-1:0] w_rem_next;
    logic [WIDTH_N-1:0] w_quo_next;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign quotient  = r_q_out;
    assign remainder = r_r_out;
    assign div_zero  = r_dz_out;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == '0);

    // One restoring step; the partial remainder carries an extra bit so divisors
    // with the MSB set cannot overflow the comparison.
    assign w_shift    = {r_rem, r_dvd[WIDTH_N-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_sub      = w_shift - {1'b0, r_dvs};
    assign w_rem_next = w_ge ? w_sub[WIDTH_D-1:0] : w_shift[WIDTH_D-1:0];
    assign w_quo_next = {r_quo[WIDTH_N-2:0], w_ge};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_q_out  <= '0;
            r_r_out  <= '0;
            r_dz_out <= 1'b0;
        end else if (w_accept) begin
            // Full dividend is loaded; only its top ITERS bits are ever consumed.
            r_dvd <= dividend;
            r_dvs <= divisor;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= CNT_W'(ITERS - 1);
            if (divisor == '0) begin
                r_q_out  <= '1;
                r_r_out  <= dividend[WIDTH_D-1:0];
                r_dz_out <= 1'b1;
            end
        end else if (r_state == S_CALC) begin
            r_dvd <= r_dvd << 1;
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
                r_q_out  <= w_quo_next << APPROX_LSB;
                r_r_out  <= w_rem_next;
                r_dz_out <= 1'b0;
            end
        end
    end

endmodule
